t9990_palette_ex: RTL
=====================

# t9990_palette_ex

Parametrised palette lookup block for the T9990 video path: it maps the per-dot palette index from the color decoder to a packed {YS,G,R,B} color word. It sits between color decode and the video output stage. Compared with the fixed 64-entry palette it adds:
- configurable entry count, channel width and pipeline delays;
- an auto-incrementing host pointer with a REQ/ACK handshake;
- a power-on clear sequencer;
- an output blanking path.

## Interface
- ENTRIES, 64: palette entries, power of two, 16..256; AW = $clog2(ENTRIES)
- CW, 5: bits per G/B channel; red stores CW+1 bits (MSB = YS)
- PA_DELAY, 1: DCLK_EN steps between PA sampling and RAM address register
- PRI_DELAY, 3: DCLK_EN steps between PRI sampling and YS merge; must be >= 1 and <= PA_DELAY+2

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- DCLK_EN  in  1  dot-clock enable, one CLK wide
- START  in  1  line start; flushes delay lines
- PA  in  AW  palette index from color decode
- PRI  in  1  priority/YS force from color decode
- BLANK  in  1  blank request, aligned with OUT stage
- OUT  out  3*CW+1  {YS, G[CW-1:0], R[CW-1:0], B[CW-1:0]}
- H_SET  in  1  load host pointer
- H_ADDR  in  AW  pointer address for H_SET
- H_CH  in  2  pointer channel for H_SET: 0=R, 1=G, 2=B, 3=none
- H_REQ  in  1  host access request (level)
- H_WE  in  1  1=write, 0=read; valid with H_REQ
- H_WDATA  in  CW+1  write data (G/B use low CW bits)
- H_NOINC  in  1  suppress pointer increment on this access
- H_RDATA  out  CW+1  read data, zero-extended for G/B
- H_ACK  out  1  one-cycle access-complete pulse
- BUSY  out  1  clear sequence in progress

## Operation
- Storage: ENTRIES x (CW+1) red, ENTRIES x CW green, ENTRIES x CW blue.
  - Pixel read port is read-only.
  - Host/clear port is single R/W.
- Clear FSM states:
  - CLEAR: counter 0..ENTRIES-1, writes 0 to all three channels each cycle, BUSY=1.
  - Leaves to IDLE after the entry ENTRIES-1 write.
  - Host requests are not granted while in CLEAR.
- Host FSM states:
  - IDLE: grant when H_REQ=1, BUSY=0 and DCLK_EN=0 → ACCESS.
  - ACCESS: perform the write or latch the read, pulse H_ACK=1, return to IDLE.
  - H_REQ seen in the H_ACK cycle is ignored; the host drops H_REQ on H_ACK.
  - If DCLK_EN=1, the request stays pending; the pixel side has priority.
- Pointer {addr, ch}:
  - Each granted access uses the current pointer.
  - If H_NOINC=0, the pointer then advances R→G→B→R with addr+1; addr wraps ENTRIES-1→0.
  - ch=3: write discarded, read returns 0, increment goes to {addr+1, R}.
  - H_SET loads the pointer in any cycle.
  - H_SET in the same cycle as a grant: the access uses the old pointer, and the pointer ends at the H_SET value.
- Pixel path, per DCLK_EN step:
  - Sample {PRI, PA} into the delay lines.
  - Register the RAM address from the PA delay line.
  - Register OUT from RAM data.
  - OUT.YS = red[CW] OR delayed PRI.
  - BLANK=1 at the OUT update forces OUT=0, including YS.
- START:
  - Clears both delay lines to 0 and the RAM address register to 0.
  - START outranks DCLK_EN in the same cycle; that cycle's PA/PRI is discarded.
  - OUT holds its value.

## Timing
- Reset values: OUT=0, H_RDATA=0, H_ACK=0, BUSY=1, pointer={0,R}, delay lines=0, FSM=CLEAR.
- BUSY falls ENTRIES cycles after RESET deasserts.
- RESET asserted mid-clear or mid-access restarts CLEAR; any pending request is dropped with no H_ACK.
- Pixel latency: PA sampled at DCLK_EN step n appears on OUT at step n+PA_DELAY+1.
- YS: PRI sampled at step n merges into OUT at step n+PRI_DELAY.
- Host latency:
  - Grant cycle g; H_ACK=1 in cycle g+1.
  - Read data is valid on H_RDATA in cycle g+1 and held until the next read.
  - A write is visible to a pixel lookup registered in cycle g+2 or later.
- Host-write and pixel read of the same entry in one cycle: the pixel gets the old data.
- OUT changes only on DCLK_EN cycles.

## Test plan
- Reset, then count cycles → BUSY=1 for exactly 64 cycles, H_ACK never asserts; afterwards PA=any gives OUT=0.
- H_SET addr=5 ch=R; three writes 0x21, 0x1F, 0x0A with DCLK_EN=0 → pointer ends {6,R}.
  - Then feed PA=5 → OUT=0x8000 | (0x1F<<10) | (0x01<<5) | 0x0A, i.e. 0xFC2A.
  - OUT appears PA_DELAY+1 steps after PA.
- Write at H_SET addr=63 ch=B → pointer wraps to {0,R}.
  - Read with H_NOINC=1 → H_RDATA valid with H_ACK, pointer unchanged.
- Hold H_REQ while DCLK_EN=1 for 3 cycles → no grant; grant in the first DCLK_EN=0 cycle; H_ACK the next cycle.
- PRI=1 at step n with entry YS=0 → OUT[15]=1 exactly at step n+PRI_DELAY.
  - BLANK=1 on the same step → OUT=0.
- Assert START mid-line, then PA=7 → OUT shows palette[0] for PA_DELAY+1 steps, then palette[7].
  - Separately: RESET during an access → no H_ACK, BUSY=1 again.

Source files
------------

// File: rtl/t9990_palette_ex_if.sv
// T9990 palette host port: pointer load, request/acknowledge access, clear status.
// The master drives the pointer and access controls; the palette block answers as slave.
interface t9990_palette_ex_if #(
    parameter int AW = 6,
    parameter int CW = 5
);
    logic          H_SET;
    logic [AW-1:0] H_ADDR;
    logic [1:0]    H_CH;
    logic          H_REQ;
    logic          H_WE;
    logic [CW:0]   H_WDATA;
    logic          H_NOINC;
    logic [CW:0]   H_RDATA;
    logic          H_ACK;
    logic          BUSY;

    modport master (
        output H_SET, H_ADDR, H_CH, H_REQ, H_WE, H_WDATA, H_NOINC,
        input  H_RDATA, H_ACK, BUSY
    );

    modport slave (
        input  H_SET, H_ADDR, H_CH, H_REQ, H_WE, H_WDATA, H_NOINC,
        output H_RDATA, H_ACK, BUSY
    );
endinterface

// File: rtl/t9990_palette_ex.sv
// T9990 palette lookup: dot index to {YS,G,R,B}, host pointer port,
// power-on clear and output blanking.
module t9990_palette_ex #(
    parameter int ENTRIES   = 64,
    parameter int CW        = 5,
    parameter int PA_DELAY  = 1,
    parameter int PRI_DELAY = 3,
    localparam int AW = $clog2(ENTRIES)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          DCLK_EN,
    input  logic          START,
    input  logic [AW-1:0] PA,
    input  logic          PRI,
    input  logic          BLANK,
    output logic [3*CW:0] OUT,
    t9990_palette_ex_if.slave host
);
    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    logic [CW:0]   red [ENTRIES];
    logic [CW-1:0] grn [ENTRIES];
    logic [CW-1:0] blu [ENTRIES];

    logic [1:0]    state;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] ptr_addr, acc_addr;
    logic [1:0]    ptr_ch, acc_ch;
    logic [AW-1:0] nxt_addr;
    logic [1:0]    nxt_ch;
    logic [CW:0]   acc_wdata;
    logic          acc_we;
    logic          grant;
    logic [CW:0]   rd_mux;

    logic [AW-1:0] wa;
    logic [CW:0]   wd;
    logic [2:0]    wsel;

    logic [AW-1:0] pa_tap;
    logic [AW-1:0] ra;
    logic          pri_dl [PRI_DELAY];

    // The pixel side owns DCLK_EN cycles; host grants wait for a gap.
    assign grant      = (state == ST_IDLE) && host.H_REQ && !DCLK_EN;
    assign host.BUSY  = (state == ST_CLEAR);
    assign host.H_ACK = (state == ST_ACCESS);

    always_comb begin
        rd_mux = '0;
        case (ptr_ch)
            CH_R:    rd_mux = red[ptr_addr];
            CH_G:    rd_mux = {1'b0, grn[ptr_addr]};
            CH_B:    rd_mux = {1'b0, blu[ptr_addr]};
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        nxt_addr = ptr_addr;
        nxt_ch   = CH_R;
        case (ptr_ch)
            CH_R:    nxt_ch = CH_G;
            CH_G:    nxt_ch = CH_B;
            default: nxt_addr = ptr_addr + 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            ptr_addr     <= '0;
            ptr_ch       <= CH_R;
            acc_addr     <= '0;
            acc_ch       <= CH_R;
            acc_we       <= 1'b0;
            acc_wdata    <= '0;
            host.H_RDATA <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(ENTRIES - 1))
                        state <= ST_IDLE;
                end
                ST_IDLE:   if (grant) state <= ST_ACCESS;
                ST_ACCESS: state <= ST_IDLE;
                default:   state <= ST_CLEAR;
            endcase
            if (grant) begin
                acc_we    <= host.H_WE;
                acc_addr  <= ptr_addr;
                acc_ch    <= ptr_ch;
                acc_wdata <= host.H_WDATA;
                if (!host.H_WE)
                    host.H_RDATA <= rd_mux;
            end
            if (host.H_SET) begin
                ptr_addr <= host.H_ADDR;
                ptr_ch   <= host.H_CH;
            end else if (grant && !host.H_NOINC) begin
                ptr_addr <= nxt_addr;
                ptr_ch   <= nxt_ch;
            end
        end
    end

    // Single host/clear write port; channel 3 writes fall through to nothing.
    always_comb begin
        wa   = acc_addr;
        wd   = acc_wdata;
        wsel = 3'b000;
        if (state == ST_CLEAR) begin
            wa   = clr_cnt;
            wd   = '0;
            wsel = 3'b111;
        end else if (state == ST_ACCESS && acc_we && !RESET) begin
            case (acc_ch)
                CH_R:    wsel = 3'b001;
                CH_G:    wsel = 3'b010;
                CH_B:    wsel = 3'b100;
                default: wsel = 3'b000;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wsel[0]) red[wa] <= wd;
        if (wsel[1]) grn[wa] <= wd[CW-1:0];
        if (wsel[2]) blu[wa] <= wd[CW-1:0];
    end

    generate
        if (PA_DELAY == 0) begin : g_pa_direct
            assign pa_tap = PA;
        end else begin : g_pa_line
            logic [AW-1:0] pa_dl [PA_DELAY];
            always_ff @(posedge CLK) begin
                if (RESET || START) begin
                    for (int i = 0; i < PA_DELAY; i++) pa_dl[i] <= '0;
                end else if (DCLK_EN) begin
                    pa_dl[0] <= PA;
                    for (int i = 1; i < PA_DELAY; i++) pa_dl[i] <= pa_dl[i-1];
                end
            end
            assign pa_tap = pa_dl[PA_DELAY-1];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET || START) begin
            for (int i = 0; i < PRI_DELAY; i++) pri_dl[i] <= 1'b0;
            ra <= '0;
        end else if (DCLK_EN) begin
            pri_dl[0] <= PRI;
            for (int i = 1; i < PRI_DELAY; i++) pri_dl[i] <= pri_dl[i-1];
            ra <= pa_tap;
        end
    end

    // OUT freezes across START so the line restart shows no glitch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT <= '0;
        end else if (DCLK_EN && !START) begin
            if (BLANK)
                OUT <= '0;
            else
                OUT <= {red[ra][CW] | pri_dl[PRI_DELAY-1], grn[ra],
                        red[ra][CW-1:0], blu[ra]};
        end
    end
endmodule
